// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants and round helper functions
package aes_pkg;

    localparam int AES_LATENCY = 21;

    // Element r holds the round constant for key-expansion step r.
    localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are {a0, a1, a2, a3} with a0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i = 4*col + row lives at bits [127-8i -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box ROM
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_ROM[a];

endmodule

// File: rtl/aes128.sv
// rtl/aes128.sv - fully pipelined AES-128 forward cipher, 21-cycle latency
module aes128
    import aes_pkg::*;
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    // Index r carries the data/key pair at the end of round r (0 = whitening).
    logic [127:0] roundData [0:10];
    logic [127:0] roundKey  [0:10];
    logic [127:0] whiteData, whiteKey;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            whiteData <= '0;
            whiteKey  <= '0;
        end else begin
            whiteData <= state ^ key;
            whiteKey  <= key;
        end
    end

    assign roundData[0] = whiteData;
    assign roundKey[0]  = whiteKey;

    for (genvar r = 1; r <= 10; r++) begin : gRound
        logic [127:0] subData, subReg, keyNext, keyReg, linearData, dataReg, keyHold;
        logic [31:0]  subWord, rotSub, w0, w1, w2, w3;

        for (genvar b = 0; b < 16; b++) begin : gDataSbox
            aes_sbox uSbox (.a(roundData[r-1][8*b +: 8]), .y(subData[8*b +: 8]));
        end

        // SubWord of the last key word; rotating afterwards equals rotating first.
        for (genvar b = 0; b < 4; b++) begin : gKeySbox
            aes_sbox uSbox (.a(roundKey[r-1][8*b +: 8]), .y(subWord[8*b +: 8]));
        end

        assign rotSub  = {subWord[23:0], subWord[31:24]};
        assign w0      = roundKey[r-1][127:96] ^ rotSub ^ {RCON[r], 24'h000000};
        assign w1      = roundKey[r-1][95:64] ^ w0;
        assign w2      = roundKey[r-1][63:32] ^ w1;
        assign w3      = roundKey[r-1][31:0]  ^ w2;
        assign keyNext = {w0, w1, w2, w3};

        if (r == 10) begin : gFinal
            assign linearData = shift_rows(subReg);
        end else begin : gMix
            logic [127:0] shifted;
            assign shifted    = shift_rows(subReg);
            assign linearData = {mix_column(shifted[127:96]), mix_column(shifted[95:64]),
                                 mix_column(shifted[63:32]),  mix_column(shifted[31:0])};
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                subReg  <= '0;
                keyReg  <= '0;
                dataReg <= '0;
                keyHold <= '0;
            end else begin
                subReg  <= subData;
                keyReg  <= keyNext;
                dataReg <= linearData ^ keyReg;
                keyHold <= keyReg;
            end
        end

        assign roundData[r] = dataReg;
        assign roundKey[r]  = keyHold;
    end

    assign out = roundData[10];

endmodule

// File: tb/tb_aes128.sv
// tb/tb_aes128.sv - directed and model-checked bench for aes128
module tb_aes128;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [127:0] state = '0;
    logic [127:0] key   = '0;
    logic [127:0] out;

    int errCount   = 0;
    int checkCount = 0;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128 dut (
        .Clock (Clock),
        .Reset (Reset),
        .state (state),
        .key   (key),
        .out   (out)
    );

    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference AES built from GF(2^8) arithmetic rather than a lookup table.
    logic [7:0] sbTab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [127:0] aesModel(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] rk [16];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127 - 8 * i -: 8];
            s[i]  = pt[127 - 8 * i -: 8] ^ rk[i];
        end
        for (int r = 1; r <= 10; r++) begin
            tmp[0] = sbTab[rk[13]] ^ rc;
            tmp[1] = sbTab[rk[14]];
            tmp[2] = sbTab[rk[15]];
            tmp[3] = sbTab[rk[12]];
            for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ tmp[i];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i - 4];
            rc = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4 * c + row] = sbTab[s[4 * ((c + row) % 4) + row]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c+0], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c+0] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c+0] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c+0], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Expected-output pipeline: slot 20 is what out must show after the current edge.
    logic [127:0] pipeVal [21];
    bit           pipeVld [21];

    task automatic step(input logic [127:0] st, input logic [127:0] k, input bit rst);
        state = st;
        key   = k;
        Reset = rst;
        @(posedge Clock);
        if (rst) begin
            for (int i = 0; i < 21; i++) pipeVld[i] = 1'b0;
        end else begin
            for (int i = 20; i > 0; i--) begin
                pipeVal[i] = pipeVal[i - 1];
                pipeVld[i] = pipeVld[i - 1];
            end
            pipeVal[0] = aesModel(st, k);
            pipeVld[0] = 1'b1;
        end
        #1;
        if (rst) checkVal("reset_zero", out, 128'd0);
        else if (pipeVld[20]) checkVal("model", out, pipeVal[20]);
    endtask

    logic [127:0] flushed [10];
    logic [127:0] rs, rk2;

    initial begin
        sbTab[0] = 8'h63;
        for (int b = 1; b < 256; b++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sbTab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 21; i++) begin
            pipeVld[i] = 1'b0;
            pipeVal[i] = '0;
        end

        step('0, '0, 1'b1);
        step('0, '0, 1'b1);

        // Constant C.1 inputs: not ready after 20 edges, correct after 21 and held.
        for (int i = 1; i <= 22; i++) begin
            step(PT_C1, KEY_C1, 1'b0);
            if (i == 20) checkVal("c1_early", {127'd0, out == CT_C1}, 128'd0);
            if (i == 21) checkVal("c1_vector", out, CT_C1);
            if (i == 22) checkVal("c1_hold", out, CT_C1);
        end

        // Streaming three vectors then counter blocks, one per cycle.
        step('0, '0, 1'b1);
        step(PT_C1, KEY_C1, 1'b0);
        step(PT_B, KEY_B, 1'b0);
        step('0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(128'(i), KEY_C1, 1'b0);
        for (int i = 12; i <= 20; i++) step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        checkVal("stream_c1", out, CT_C1);
        step('0, '0, 1'b0);
        checkVal("stream_b", out, CT_B);
        step('0, '0, 1'b0);
        checkVal("stream_zero", out, CT_Z);
        for (int i = 0; i < 10; i++) step('0, '0, 1'b0);

        // Mid-stream reset flushes ten blocks in flight.
        for (int i = 0; i < 10; i++) begin
            rs  = {$urandom, $urandom, $urandom, $urandom};
            rk2 = {$urandom, $urandom, $urandom, $urandom};
            flushed[i] = aesModel(rs, rk2);
            step(rs, rk2, 1'b0);
        end
        step('0, '0, 1'b1);
        step(PT_B, KEY_B, 1'b0);
        for (int i = 2; i <= 21; i++) begin
            for (int j = 0; j < 10; j++) checkVal("flushed_absent", {127'd0, out == flushed[j]}, 128'd0);
            step('0, '0, 1'b0);
        end
        checkVal("post_reset_b", out, CT_B);

        // Random regression, key changing every cycle.
        for (int i = 0; i < 10000; i++)
            step({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        for (int i = 0; i < 21; i++) step('0, '0, 1'b0);
        checkVal("drain_zero", out, CT_Z);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
